// File: rtl/number_entry_sequencer_if.sv
// Operand-entry bus between the number entry sequencer and its surroundings:
// raw switches/buttons in, five captured words plus start/busy status out.
interface number_entry_sequencer_if;
  logic [3:0] sw;
  logic       enter;
  logic       clear;
  logic       load;
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic [3:0] q4;
  logic [2:0] count;
  logic       st;
  logic       busy;

  modport slave (
    input  sw, enter, clear, load,
    output q0, q1, q2, q3, q4, count, st, busy
  );

  modport master (
    output sw, enter, clear, load,
    input  q0, q1, q2, q3, q4, count, st, busy
  );
endinterface

// File: rtl/number_entry_sequencer.sv
// Collects five 4-bit operands on debounced enter presses, pulses start to the
// two-largest selector, and holds the words until the selector reports load.
module number_entry_sequencer #(
  parameter int unsigned DEBOUNCE = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  number_entry_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_ENTER, S_START, S_WAIT, S_HOLD} state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE - 1);

  logic [1:0]  rst_sync;
  logic        rst_ni;
  logic [5:0]  in_p0;
  logic [5:0]  in_p1;
  logic [3:0]  sw_s;
  logic [15:0] db_cnt [2];
  logic [1:0]  db;
  logic [1:0]  db_prev;
  logic [1:0]  press;
  logic        enter_press;
  logic        clear_press;

  state_t      state;
  logic [3:0]  q [5];
  logic [2:0]  count;
  logic        st;
  logic        busy;

  // Reset asserts asynchronously, releases two clocks later in step with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ni = rst_sync[1];

  // Stage p0/p1: two-flop synchronizer for {sw, clear, enter}.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      in_p0 <= '0;
      in_p1 <= '0;
    end else begin
      in_p0 <= {bus.sw, bus.clear, bus.enter};
      in_p1 <= in_p0;
    end
  end

  assign sw_s = in_p1[5:2];

  // Debouncers: bit 0 is enter, bit 1 is clear.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      db      <= '0;
      db_prev <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_p1[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db[i]     <= in_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
      db_prev <= db;
    end
  end

  assign press       = db & ~db_prev;
  assign enter_press = press[0];
  assign clear_press = press[1];

  // Entry FSM; clear has priority over every state and over a same-cycle enter.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_ENTER;
      for (int i = 0; i < 5; i++) q[i] <= '0;
      count <= '0;
      st    <= 1'b0;
      busy  <= 1'b0;
    end else if (clear_press) begin
      state <= S_ENTER;
      for (int i = 0; i < 5; i++) q[i] <= '0;
      count <= '0;
      st    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_ENTER: begin
          st   <= 1'b0;
          busy <= 1'b0;
          if (enter_press) begin
            for (int i = 0; i < 5; i++) begin
              if (count == 3'(i)) q[i] <= sw_s;
            end
            count <= count + 3'd1;
            if (count == 3'd4) begin
              state <= S_START;
              st    <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
          st    <= 1'b0;
          busy  <= 1'b1;
        end
        S_WAIT: begin
          st <= 1'b0;
          if (bus.load) begin
            state <= S_HOLD;
            busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          st   <= 1'b0;
          busy <= 1'b0;
          if (enter_press) begin
            q[0] <= sw_s;
            for (int i = 1; i < 5; i++) q[i] <= '0;
            count <= 3'd1;
            state <= S_ENTER;
          end
        end
        default: begin
          state <= S_ENTER;
          st    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q0    = q[0];
  assign bus.q1    = q[1];
  assign bus.q2    = q[2];
  assign bus.q3    = q[3];
  assign bus.q4    = q[4];
  assign bus.count = count;
  assign bus.st    = st;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_number_entry_sequencer.sv
// Bench for number_entry_sequencer: a DEBOUNCE=2 instance for exact latency,
// and a DEBOUNCE=4 instance tracked by a word/count scoreboard.
module tb_number_entry_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       enter;
  logic       clear;
  logic       load;

  number_entry_sequencer_if bus2 ();
  number_entry_sequencer_if bus4 ();

  assign bus2.sw = sw;  assign bus2.enter = enter;  assign bus2.clear = clear;  assign bus2.load = load;
  assign bus4.sw = sw;  assign bus4.enter = enter;  assign bus4.clear = clear;  assign bus4.load = load;

  number_entry_sequencer #(.DEBOUNCE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  number_entry_sequencer #(.DEBOUNCE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model of the DEBOUNCE=4 instance (mode 0 entry, 1 start/wait, 2 hold).
  logic [3:0]  exp_q [5];
  int          exp_cnt  = 0;
  int          exp_mode = 0;
  int          exp_st   = 0;
  logic [22:0] sb [$];

  function automatic logic [22:0] model_snap();
    return {exp_q[4], exp_q[3], exp_q[2], exp_q[1], exp_q[0], 3'(exp_cnt)};
  endfunction

  function automatic logic [22:0] dut4_snap();
    return {bus4.q4, bus4.q3, bus4.q2, bus4.q1, bus4.q0, bus4.count};
  endfunction

  task automatic model_enter(input logic [3:0] v);
    if (exp_mode == 0) begin
      exp_q[exp_cnt] = v;
      exp_cnt++;
      if (exp_cnt == 5) begin
        exp_mode = 1;
        exp_st++;
      end
      sb.push_back(model_snap());
    end else if (exp_mode == 2) begin
      exp_q[0] = v;
      for (int i = 1; i < 5; i++) exp_q[i] = 4'd0;
      exp_cnt  = 1;
      exp_mode = 0;
      sb.push_back(model_snap());
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++) exp_q[i] = 4'd0;
    exp_cnt  = 0;
    exp_mode = 0;
    if (sb.size() > 0 ? sb[$] != 23'd0 : dut4_snap() != 23'd0) sb.push_back(23'd0);
  endtask

  // Scoreboard: every change of the DEBOUNCE=4 words/count must match the next queued entry.
  logic [22:0] prev4 = '0;
  logic        prev_st4 = 1'b0;
  int          st_seen2 = 0;
  int          st_seen4 = 0;

  always @(negedge clk) begin
    logic [22:0] snap;
    snap = dut4_snap();
    if (snap !== prev4) begin
      if (sb.size() > 0) check_eq("sb_word", 32'(snap), 32'(sb.pop_front()));
      else               check_eq("sb_unexpected", 32'(snap), 32'(prev4));
      prev4 = snap;
    end
    if (bus4.st === 1'b1) begin
      st_seen4++;
      check_eq("st_width", 32'(prev_st4), 32'd0);
    end
    prev_st4 = bus4.st;
    if (bus2.st === 1'b1) st_seen2++;
  end

  // which: 0 enter, 1 clear, 2 both. lat_c0 >= 0 enables exact DEBOUNCE=2 latency checks.
  task automatic press(input int which, input logic [3:0] v, input int hold, input bit accept, input int lat_c0);
    @(negedge clk);
    sw = v;
    repeat (3) @(negedge clk);
    if (accept) begin
      if (which == 0) model_enter(v);
      else            model_clear();
    end
    enter = (which != 1);
    clear = (which != 0);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (lat_c0 >= 0) begin
        if (k == 4) check_eq("lat_before", 32'(bus2.count), 32'(lat_c0));
        if (k == 5) begin
          check_eq("lat_capture", 32'(bus2.count), 32'(lat_c0 + 1));
          check_eq("st_on", 32'(bus2.st), 32'(lat_c0 == 4));
          check_eq("busy_on", 32'(bus2.busy), 32'(lat_c0 == 4));
        end
        if (k == 6) begin
          check_eq("st_off", 32'(bus2.st), 32'd0);
          check_eq("busy_after_st", 32'(bus2.busy), 32'(lat_c0 == 4));
        end
      end
    end
    @(negedge clk);
    enter = 1'b0;
    clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // late=0: glitch low early in the press; late=1: glitch low after the level is accepted.
  task automatic press_glitch(input logic [3:0] v, input bit late);
    @(negedge clk);
    sw = v;
    repeat (3) @(negedge clk);
    model_enter(v);
    enter = 1'b1;
    repeat (late ? 8 : 2) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    enter = 1'b1;
    repeat (late ? 3 : 8) @(negedge clk);
    enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic fill_four();
    for (int i = 0; i < 4; i++) press(0, 4'($urandom_range(0, 15)), 8, 1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [3:0] VALS [5] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd7};

  initial begin
    for (int i = 0; i < 5; i++) exp_q[i] = 4'd0;
    rst_n = 1'b0; sw = 4'd0; enter = 1'b0; clear = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_snap4", 32'(dut4_snap()), 32'd0);
    check_eq("rst_st4", 32'(bus4.st), 32'd0);
    check_eq("rst_busy4", 32'(bus4.busy), 32'd0);
    check_eq("rst_count2", 32'(bus2.count), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Five stable presses.
    for (int i = 0; i < 5; i++) press(0, VALS[i], 8, 1, i);
    repeat (20) @(negedge clk);
    check_eq("q0_2", 32'(bus2.q0), 32'd3);
    check_eq("q1_2", 32'(bus2.q1), 32'd9);
    check_eq("q2_2", 32'(bus2.q2), 32'd0);
    check_eq("q3_2", 32'(bus2.q3), 32'd15);
    check_eq("q4_2", 32'(bus2.q4), 32'd7);
    check_eq("count_2", 32'(bus2.count), 32'd5);
    check_eq("busy_wait2", 32'(bus2.busy), 32'd1);
    check_eq("st_once2", 32'(st_seen2), 32'd1);
    check_eq("busy_wait4", 32'(bus4.busy), 32'd1);

    // Presses while waiting for load are discarded.
    press(0, 4'd12, 8, 1, -1);
    press(0, 4'd6, 8, 1, -1);
    check_eq("wait_count4", 32'(bus4.count), 32'd5);
    check_eq("wait_st4", 32'(st_seen4), 32'(exp_st));

    // load ends the wait.
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1;
    check_eq("load_busy4", 32'(bus4.busy), 32'd0);
    check_eq("load_busy2", 32'(bus2.busy), 32'd0);
    exp_mode = 2;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);

    // New set from hold.
    press(0, 4'd5, 8, 1, -1);
    check_eq("hold_q0", 32'(bus4.q0), 32'd5);
    check_eq("hold_count", 32'(bus4.count), 32'd1);

    // Short pulses are filtered; glitches on a held press give exactly one capture.
    press(0, 4'd8, 2, 0, -1);
    press(0, 4'd8, 3, 0, -1);
    check_eq("pulse_count", 32'(bus4.count), 32'd1);
    press_glitch(4'd10, 1'b1);
    press_glitch(4'd11, 1'b0);
    check_eq("glitch_count", 32'(bus4.count), 32'd3);

    // Clear at count 3.
    press(1, 4'd0, 8, 1, -1);
    check_eq("clr3_count", 32'(bus4.count), 32'd0);

    // Clear during wait.
    fill_four();
    press(0, 4'd14, 8, 1, -1);
    check_eq("pre_clr_busy", 32'(bus4.busy), 32'd1);
    press(1, 4'd0, 8, 1, -1);
    check_eq("clrw_busy", 32'(bus4.busy), 32'd0);
    check_eq("clrw_count", 32'(bus4.count), 32'd0);

    // Enter and clear together: clear wins.
    press(0, 4'd1, 8, 1, -1);
    press(0, 4'd2, 8, 1, -1);
    press(2, 4'd4, 8, 1, -1);
    check_eq("both_count", 32'(bus4.count), 32'd0);

    // Reset while st is high.
    fill_four();
    @(negedge clk);
    sw = 4'd13;
    repeat (3) @(negedge clk);
    model_enter(4'd13);
    enter = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check_eq("st_before_rst", 32'(bus4.st), 32'd1);
    @(negedge clk);
    #1;
    model_clear();
    rst_n = 1'b0;
    #1;
    check_eq("rst_st_st", 32'(bus4.st), 32'd0);
    check_eq("rst_st_busy", 32'(bus4.busy), 32'd0);
    check_eq("rst_st_snap", 32'(dut4_snap()), 32'd0);
    @(negedge clk);
    enter = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset while waiting, then the first press lands in q0.
    fill_four();
    press(0, 4'd9, 8, 1, -1);
    repeat (3) @(negedge clk);
    #2;
    model_clear();
    rst_n = 1'b0;
    #1;
    check_eq("rst_w_busy", 32'(bus4.busy), 32'd0);
    check_eq("rst_w_snap", 32'(dut4_snap()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    press(0, 4'hA, 8, 1, -1);
    check_eq("post_rst_q0", 32'(bus4.q0), 32'hA);
    check_eq("post_rst_count", 32'(bus4.count), 32'd1);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("st_total4", 32'(st_seen4), 32'(exp_st));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
